// File: rtl/boot_loader.sv
// Boot loader: holds the CPU in reset while a length-prefixed image streams into RAM,
// then hands the RAM port to the CPU bus. A reload pulse restarts loading.
module boot_loader #(
   parameter logic [29:0] BASE        = 30'h0,
   parameter int unsigned DEPTH_WORDS = 4096
) (
   input  logic        i_clock,
   input  logic        i_reset,
   input  logic        i_in_valid,
   input  logic [7:0]  i_in_data,
   output logic        o_in_ready,
   input  logic        i_reload,
   output logic        o_cpu_reset,
   input  logic [29:0] i_cpu_bus_addr,
   input  logic [31:0] i_cpu_bus_data_w,
   input  logic [3:0]  i_cpu_bus_mask_w,
   output logic [29:0] o_mem_addr,
   output logic [31:0] o_mem_data_w,
   output logic [3:0]  o_mem_mask_w,
   output logic        o_running,
   output logic        o_error
);

   localparam int unsigned AW = 30;
   localparam int unsigned DW = 32;
   localparam int unsigned MW = 4;

   typedef enum logic [2:0] {
      S_LEN_RX  = 3'd0,
      S_DATA_RX = 3'd1,
      S_WRITE   = 3'd2,
      S_RUN     = 3'd3,
      S_ERROR   = 3'd4
   } state_t;

   state_t          r_state;
   state_t          w_next;
   logic [1:0]      r_byte_idx;
   logic [23:0]     r_shift;
   logic [DW-1:0]   r_len;
   logic [DW-1:0]   r_word_cnt;
   logic [AW-1:0]   r_ld_addr;
   logic [DW-1:0]   r_ld_data;
   logic [MW-1:0]   r_ld_mask;
   logic            r_cpu_reset;
   logic            r_running;
   logic            r_error;
   logic            r_sel;

   logic            w_in_ready;
   logic            w_xfer;
   logic            w_last_byte;
   logic [DW-1:0]   w_word;

   // State register
   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) r_state <= S_LEN_RX;
      else         r_state <= w_next;
   end

   // Next-state, handshake and little-endian word assembly
   always_comb begin
      w_next      = r_state;
      w_in_ready  = 1'b0;
      w_word      = {i_in_data, r_shift};
      w_last_byte = (r_byte_idx == 2'd3);
      case (r_state)
         S_LEN_RX: begin
            w_in_ready = 1'b1;
            if (i_in_valid && w_last_byte) begin
               if (w_word == DW'(0))                    w_next = S_RUN;
               else if (w_word > DW'(DEPTH_WORDS))       w_next = S_ERROR;
               else                                      w_next = S_DATA_RX;
            end
         end
         S_DATA_RX: begin
            w_in_ready = 1'b1;
            if (i_in_valid && w_last_byte) w_next = S_WRITE;
         end
         S_WRITE: begin
            if (r_word_cnt + DW'(1) == r_len) w_next = S_RUN;
            else                              w_next = S_DATA_RX;
         end
         S_RUN, S_ERROR: begin
            if (i_reload) w_next = S_LEN_RX;
         end
         default: w_next = S_LEN_RX;
      endcase
      w_xfer = i_in_valid & w_in_ready;
   end

   // Loader datapath and registered status outputs
   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         r_byte_idx  <= 2'd0;
         r_shift     <= 24'd0;
         r_len       <= DW'(0);
         r_word_cnt  <= DW'(0);
         r_ld_addr   <= BASE;
         r_ld_data   <= DW'(0);
         r_ld_mask   <= MW'(0);
         r_cpu_reset <= 1'b1;
         r_running   <= 1'b0;
         r_error     <= 1'b0;
         r_sel       <= 1'b0;
      end else begin
         if (w_xfer) begin
            r_shift    <= w_word[31:8];
            r_byte_idx <= r_byte_idx + 2'd1;
         end
         case (r_state)
            S_LEN_RX: begin
               if (w_xfer && w_last_byte) begin
                  r_len      <= w_word;
                  r_word_cnt <= DW'(0);
               end
            end
            S_DATA_RX: begin
               if (w_xfer && w_last_byte) begin
                  r_ld_addr <= BASE + AW'(r_word_cnt);
                  r_ld_data <= w_word;
                  r_ld_mask <= MW'(4'hF);
               end
            end
            S_WRITE: begin
               r_ld_mask  <= MW'(0);
               r_word_cnt <= r_word_cnt + DW'(1);
            end
            S_RUN, S_ERROR: begin
               if (i_reload) begin
                  r_byte_idx <= 2'd0;
                  r_word_cnt <= DW'(0);
                  r_ld_mask  <= MW'(0);
               end
            end
            default: ;
         endcase
         r_cpu_reset <= (w_next != S_RUN);
         r_running   <= (w_next == S_RUN);
         r_error     <= (w_next == S_ERROR);
         r_sel       <= (w_next == S_RUN);
      end
   end

   // RAM port: CPU bus passes straight through once running
   assign o_mem_addr   = r_sel ? i_cpu_bus_addr   : r_ld_addr;
   assign o_mem_data_w = r_sel ? i_cpu_bus_data_w : r_ld_data;
   assign o_mem_mask_w = r_sel ? i_cpu_bus_mask_w : r_ld_mask;

   assign o_in_ready  = w_in_ready;
   assign o_cpu_reset = r_cpu_reset;
   assign o_running   = r_running;
   assign o_error     = r_error;

endmodule

// File: tb/tb_boot_loader.sv
// Bench for boot_loader: per-cycle vector table for a 2-word image plus sequences for
// reload, zero length, oversize length, stalled stream and asynchronous reset.
module tb_boot_loader;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        valid = 1'b0;
   logic [7:0]  din = 8'h00;
   logic        reload = 1'b0;
   logic [29:0] caddr = 30'h0;
   logic [31:0] cdata = 32'h0;
   logic [3:0]  cmask = 4'h0;

   logic        in_ready;
   logic        cpu_reset;
   logic [29:0] mem_addr;
   logic [31:0] mem_data;
   logic [3:0]  mem_mask;
   logic        running;
   logic        error;

   boot_loader dut (
      .i_clock          (clk),
      .i_reset          (rst),
      .i_in_valid       (valid),
      .i_in_data        (din),
      .o_in_ready       (in_ready),
      .i_reload         (reload),
      .o_cpu_reset      (cpu_reset),
      .i_cpu_bus_addr   (caddr),
      .i_cpu_bus_data_w (cdata),
      .i_cpu_bus_mask_w (cmask),
      .o_mem_addr       (mem_addr),
      .o_mem_data_w     (mem_data),
      .o_mem_mask_w     (mem_mask),
      .o_running        (running),
      .o_error          (error)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [29:0] addr;
      logic [31:0] data;
   } wr_t;

   typedef struct {
      logic       v;
      logic [7:0] d;
      logic [3:0] cm;
      logic       e_rdy;
      logic       e_run;
      logic       e_crst;
      logic       e_err;
      logic [3:0] e_mask;
   } vec_t;

   wr_t  exp_q[$];
   vec_t tbl[15];
   int   errors = 0;
   int   checks = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // RAM write monitor: every loader write must match the next expected write
   always @(negedge clk) begin : mon
      wr_t e;
      if (!rst && mem_mask != 4'h0 && !running) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write: addr %0h data %0h mask %0h (t=%0t)",
                     mem_addr, mem_data, mem_mask, $time);
         end else begin
            e = exp_q.pop_front();
            chk("wr_addr", 32'(mem_addr), 32'(e.addr));
            chk("wr_data", mem_data, e.data);
            chk("wr_mask", 32'(mem_mask), 32'h0000000F);
         end
      end
   end

   task automatic send_byte(input logic [7:0] b, input int gap, output int stalls);
      stalls = 0;
      for (int g = 0; g < gap; g++) begin
         valid = 1'b0;
         @(posedge clk); @(negedge clk);
      end
      valid = 1'b1;
      din   = b;
      for (int t = 0; t < 20; t++) begin
         if (in_ready) begin
            @(posedge clk); @(negedge clk);
            valid = 1'b0;
            return;
         end
         stalls++;
         @(posedge clk); @(negedge clk);
      end
      valid = 1'b0;
      checks++;
      errors++;
      $display("FAIL send_byte_timeout: byte %0h not accepted, required within 20 cycles", b);
   endtask

   task automatic send_word(input logic [31:0] w, input int gap);
      int s;
      for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], gap, s);
   endtask

   task automatic pulse_reload();
      reload = 1'b1;
      @(posedge clk); @(negedge clk);
      reload = 1'b0;
   endtask

   task automatic wait_running(input int bound);
      for (int t = 0; t < bound; t++) begin
         if (running) break;
         @(posedge clk); @(negedge clk);
      end
      chk("wait_running", 32'(running), 32'd1);
   endtask

   initial begin
      int s;
      tbl[0]  = '{1'b1, 8'h02, 4'h0, 1'b1, 1'b0, 1'b1, 1'b0, 4'h0};
      tbl[1]  = '{1'b1, 8'h00, 4'h0, 1'b1, 1'b0, 1'b1, 1'b0, 4'h0};
      tbl[2]  = '{1'b1, 8'h00, 4'h0, 1'b1, 1'b0, 1'b1, 1'b0, 4'h0};
      tbl[3]  = '{1'b1, 8'h00, 4'h0, 1'b1, 1'b0, 1'b1, 1'b0, 4'h0};
      tbl[4]  = '{1'b1, 8'h13, 4'h0, 1'b1, 1'b0, 1'b1, 1'b0, 4'h0};
      tbl[5]  = '{1'b1, 8'h00, 4'h0, 1'b1, 1'b0, 1'b1, 1'b0, 4'h0};
      tbl[6]  = '{1'b1, 8'h00, 4'h0, 1'b1, 1'b0, 1'b1, 1'b0, 4'h0};
      tbl[7]  = '{1'b1, 8'h00, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 4'hF};
      tbl[8]  = '{1'b1, 8'h93, 4'h0, 1'b1, 1'b0, 1'b1, 1'b0, 4'h0};
      tbl[9]  = '{1'b1, 8'h93, 4'h0, 1'b1, 1'b0, 1'b1, 1'b0, 4'h0};
      tbl[10] = '{1'b1, 8'h00, 4'h0, 1'b1, 1'b0, 1'b1, 1'b0, 4'h0};
      tbl[11] = '{1'b1, 8'h10, 4'h0, 1'b1, 1'b0, 1'b1, 1'b0, 4'h0};
      tbl[12] = '{1'b1, 8'h00, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 4'hF};
      tbl[13] = '{1'b0, 8'h00, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0};
      tbl[14] = '{1'b0, 8'h00, 4'h3, 1'b0, 1'b1, 1'b0, 1'b0, 4'h3};

      // Reset values
      repeat (2) @(negedge clk);
      chk("rst_ready", 32'(in_ready), 32'd1);
      chk("rst_cpu_reset", 32'(cpu_reset), 32'd1);
      chk("rst_running", 32'(running), 32'd0);
      chk("rst_error", 32'(error), 32'd0);
      chk("rst_mask", 32'(mem_mask), 32'd0);
      chk("rst_addr", 32'(mem_addr), 32'd0);
      chk("rst_data", mem_data, 32'd0);
      rst = 1'b0;

      // Two-word image, one vector per cycle
      exp_q.push_back('{30'd0, 32'h00000013});
      exp_q.push_back('{30'd1, 32'h00100093});
      for (int i = 0; i < 15; i++) begin
         valid = tbl[i].v;
         din   = tbl[i].d;
         cmask = tbl[i].cm;
         @(posedge clk); @(negedge clk);
         chk($sformatf("vec%0d_ready", i), 32'(in_ready), 32'(tbl[i].e_rdy));
         chk($sformatf("vec%0d_running", i), 32'(running), 32'(tbl[i].e_run));
         chk($sformatf("vec%0d_cpu_reset", i), 32'(cpu_reset), 32'(tbl[i].e_crst));
         chk($sformatf("vec%0d_error", i), 32'(error), 32'(tbl[i].e_err));
         chk($sformatf("vec%0d_mask", i), 32'(mem_mask), 32'(tbl[i].e_mask));
      end
      valid = 1'b0;

      // Reload in Run drops the in-flight CPU store
      caddr = 30'h7;
      cmask = 4'h3;
      reload = 1'b1;
      chk("reload_pre_mask", 32'(mem_mask), 32'h3);
      @(posedge clk); @(negedge clk);
      reload = 1'b0;
      chk("reload_mask", 32'(mem_mask), 32'h0);
      chk("reload_cpu_reset", 32'(cpu_reset), 32'd1);
      chk("reload_running", 32'(running), 32'd0);
      chk("reload_ready", 32'(in_ready), 32'd1);
      exp_q.push_back('{30'd0, 32'hDEADBEEF});
      send_word(32'd1, 0);
      send_word(32'hDEADBEEF, 0);
      wait_running(5);
      chk("reload_run_addr", 32'(mem_addr), 32'h7);
      chk("reload_run_mask", 32'(mem_mask), 32'h3);

      // Zero length goes straight to Run
      pulse_reload();
      send_word(32'd0, 0);
      chk("len0_running", 32'(running), 32'd1);
      chk("len0_cpu_reset", 32'(cpu_reset), 32'd0);
      caddr = 30'h123;
      cdata = 32'hCAFEF00D;
      cmask = 4'h5;
      #1;
      chk("len0_addr", 32'(mem_addr), 32'h123);
      chk("len0_data", mem_data, 32'hCAFEF00D);
      chk("len0_mask", 32'(mem_mask), 32'h5);

      // Oversize length: DEPTH_WORDS+1
      pulse_reload();
      send_word(32'h00001001, 0);
      chk("err_error", 32'(error), 32'd1);
      chk("err_cpu_reset", 32'(cpu_reset), 32'd1);
      chk("err_ready", 32'(in_ready), 32'd0);
      chk("err_running", 32'(running), 32'd0);
      valid = 1'b1;
      din   = 8'hAA;
      repeat (3) begin @(posedge clk); @(negedge clk); end
      chk("err_hold_ready", 32'(in_ready), 32'd0);
      chk("err_hold_error", 32'(error), 32'd1);
      valid = 1'b0;
      pulse_reload();
      chk("err_reload_error", 32'(error), 32'd0);
      chk("err_reload_ready", 32'(in_ready), 32'd1);
      chk("err_reload_cpu_reset", 32'(cpu_reset), 32'd1);

      // Stream with gaps; byte after the first word stalls through the Write cycle
      exp_q.push_back('{30'd0, 32'h11223344});
      exp_q.push_back('{30'd1, 32'h55667788});
      send_word(32'd2, 1);
      send_word(32'h11223344, 1);
      send_byte(8'h88, 0, s);
      chk("gap_stalls", 32'(s), 32'd1);
      send_byte(8'h77, 1, s);
      send_byte(8'h66, 1, s);
      send_byte(8'h55, 1, s);
      wait_running(5);

      // Length exactly DEPTH_WORDS is accepted
      pulse_reload();
      send_word(32'h00001000, 0);
      chk("maxlen_error", 32'(error), 32'd0);
      chk("maxlen_ready", 32'(in_ready), 32'd1);

      // Asynchronous reset after two data bytes
      send_byte(8'hAB, 0, s);
      send_byte(8'hCD, 0, s);
      chk("pre_rst_addr", 32'(mem_addr), 32'h1);
      #2;
      rst = 1'b1;
      #1;
      chk("arst_ready", 32'(in_ready), 32'd1);
      chk("arst_cpu_reset", 32'(cpu_reset), 32'd1);
      chk("arst_running", 32'(running), 32'd0);
      chk("arst_mask", 32'(mem_mask), 32'd0);
      chk("arst_addr", 32'(mem_addr), 32'd0);
      chk("arst_data", mem_data, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      exp_q.push_back('{30'd0, 32'h0BADCAFE});
      send_word(32'd1, 0);
      send_word(32'h0BADCAFE, 0);
      wait_running(5);

      @(negedge clk);
      chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/boot_loader.md
Name: boot_loader

Overview:
- Sequences the CPU core: holds it in reset while a program image arrives over a byte stream and is written into the shared instruction/data RAM, then releases reset.
- Owns the RAM port. The port is muxed to the loader while loading and passed through from the CPU bus while running.
- A reload pulse returns to loading without a global reset.

Parameters:
- BASE, 30'h0, word address written by the first image word.
- DEPTH_WORDS, 4096, maximum image length in 32-bit words; larger counts are rejected.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous active-high reset
- in_valid  in  1  stream byte valid
- in_data  in  8  stream byte
- in_ready  out  1  loader accepts byte this cycle
- reload  in  1  single-cycle request to reload the image
- cpu_reset  out  1  synchronous reset driven to the CPU
- cpu_bus_addr  in  30  CPU word address
- cpu_bus_data_w  in  32  CPU write data
- cpu_bus_mask_w  in  4  CPU byte write mask
- mem_addr  out  30  RAM word address
- mem_data_w  out  32  RAM write data
- mem_mask_w  out  4  RAM byte write mask
- running  out  1  CPU released
- error  out  1  image length exceeded DEPTH_WORDS

Behaviour:
- Reset is asynchronous and active-high. While it is asserted:
  - state=LenRx, cpu_reset=1, running=0, error=0
  - loader mask=0, loader addr=BASE, loader data=0
  - byte index=0, word count=0
- Handshake: a byte transfers on a rising edge with in_valid&in_ready. in_ready is combinational from state: 1 in LenRx and DataRx, 0 otherwise (so 1 from reset).
- Bytes are assembled little-endian: the first byte goes to [7:0], the fourth to [31:24].
- LenRx:
  - Collect 4 bytes into N (32-bit).
  - On the 4th byte, the next state depends on N:
    - N==0: go to Run.
    - N>DEPTH_WORDS (unsigned 32-bit compare): go to Error.
    - Otherwise: go to DataRx.
  - Word index i is cleared.
- DataRx:
  - Collect 4 bytes.
  - On the edge accepting the 4th byte, register mem_addr=BASE+i (30-bit, wraps modulo 2^30), mem_data_w=word, mem_mask_w=4'hF, and go to Write.
- Write:
  - Lasts exactly one cycle; the RAM samples the write on the following edge.
  - On that edge: mask is cleared to 0 and i increments.
  - If i+1==N, go to Run; otherwise return to DataRx.
  - in_ready is 0, so no byte is lost.
- Run:
  - cpu_reset=0 and running=1, both registered and effective the cycle after entry.
  - The CPU first executes from its own reset PC with the loaded image.
- Error:
  - cpu_reset=1, error=1, in_ready=0.
  - Incoming bytes are back-pressured.
- Mem mux:
  - The select is registered and equals (state==Run).
  - When selected, mem_addr/mem_data_w/mem_mask_w = cpu_bus_* combinationally. Otherwise they take the loader registers.
  - Because the CPU has been held in reset, the first Run cycle presents addr 0, mask 0.
- reload:
  - Sampled only in Run and Error; ignored in LenRx/DataRx/Write.
  - On the sampling edge: state=LenRx, cpu_reset=1, running=0, error=0, byte index and i cleared, loader mask=0.
  - A CPU store in flight that cycle is dropped: the select falls with the same edge.
- Simultaneous reload with in_valid in Run: the byte is not accepted (in_ready is 0 in Run).
- Reset mid-operation (any state): immediate return to reset values. Partial words are discarded; RAM contents are untouched except by already-completed Write cycles.
- A partial byte index persists across in_valid gaps; there is no timeout.
- Output mem_mask_w is never nonzero in LenRx, DataRx or Error.

Test Plan:
- Reset, then stream len=2 bytes 02 00 00 00, words 13 00 00 00 | 93 00 10 00 -> two Write cycles:
  - addr 0 data 32'h00000013 mask F
  - addr 1 data 32'h00100093 mask F
  - running=1 and cpu_reset=0 one cycle after the second Write.
- len=0 (00 00 00 00) -> no Write cycles, Run entered immediately, mem_* follow cpu_bus_*.
- len=DEPTH_WORDS+1 (01 10 00 00 with default) -> error=1, cpu_reset=1, in_ready=0, no RAM writes; then reload pulse -> error=0, in_ready=1, LenRx.
- in_valid toggled every other cycle during DataRx, with the 4th byte followed by in_valid held high -> in_ready=0 during Write, the held byte is accepted the next cycle, and words are assembled correctly.
- In Run, pulse reload while cpu_bus_mask_w=4'h3:
  - mem_mask_w=0 from the next cycle, cpu_reset=1.
  - A new image of 1 word is written at BASE, then Run re-entered.
- Assert reset after 2 data bytes of word 1 -> all outputs at reset values immediately (asynchronous). The following fresh stream loads correctly from byte 0.
